rmii_rx_deframer: RTL

- Receive-side RMII front end at 100 Mb/s. Sits between the PHY pins (i_erxd, i_erx_dv, i_erx_er) and the MAC receive buffer.
- Strips preamble and SFD, assembles dibits into bytes (LSB first), checks the FCS and enforces length limits.
- Emits a byte stream with start and end markers, per-frame status, and saturating statistics counters.
- In loopback benches it consumes exactly what the MAC transmit side drives on o_etxd/o_etx_en.

---
 rtl/rmii_rx_deframer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rmii_rx_deframer.sv
// rmii_rx_deframer
//   Receive-side RMII front end (100 Mb/s, one dibit per 50 MHz clock).
//   Strips preamble/SFD, assembles dibits LSB-first into bytes, runs the
//   Ethernet CRC-32 residue check, enforces frame length limits and emits a
//   byte stream with sof/eof markers plus per-frame status and counters.
//
// Ports
//   clk          RMII 50 MHz reference clock
//   rst          asynchronous, active-high reset
//   i_erxd       receive dibit, bit 0 earliest in time
//   i_erx_dv     CRS_DV, used as pure data-valid
//   i_erx_er     PHY receive error
//   o_rx_data    received byte
//   o_rx_valid   one-cycle strobe qualifying o_rx_data
//   o_rx_sof     first byte of a frame
//   o_rx_eof     last byte of a frame (last FCS byte)
//   o_rx_crc_ok  with eof: CRC residue matched
//   o_rx_err     with eof: any error in the frame
//   o_rx_len     with eof: byte count including FCS
//   o_good_cnt   saturating count of error-free frames
//   o_bad_cnt    saturating count of errored and dropped frames
module rmii_rx_deframer #(
  parameter int MIN_PRE = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_erxd,
  input  logic             i_erx_dv,
  input  logic             i_erx_er,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  output logic             o_rx_sof,
  output logic             o_rx_eof,
  output logic             o_rx_crc_ok,
  output logic             o_rx_err,
  output logic [LEN_W-1:0] o_rx_len,
  output logic [15:0]      o_good_cnt,
  output logic [15:0]      o_bad_cnt
);

  localparam int                 PRE_W     = (MIN_PRE < 1) ? 1 : $clog2(MIN_PRE + 1);
  localparam logic [PRE_W-1:0]   MIN_PRE_C = PRE_W'(MIN_PRE);
  localparam logic [LEN_W-1:0]   MIN_LEN_C = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]   MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [31:0]        CRC_POLY  = 32'hEDB88320;
  localparam logic [31:0]        CRC_RES   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_END,
    S_DROP
  } state_t;

  // Reflected CRC-32 update over one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [PRE_W-1:0] sat_inc_pre(input logic [PRE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // ---- stage p0: pin registers ----
  logic [1:0] erxd_p0;
  logic       dv_p0;
  logic       er_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      erxd_p0 <= 2'b00;
      dv_p0   <= 1'b0;
      er_p0   <= 1'b0;
    end else begin
      erxd_p0 <= i_erxd;
      dv_p0   <= i_erx_dv;
      er_p0   <= i_erx_er;
    end
  end

  // ---- stage p1: framing FSM and byte assembly ----
  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       asm_p1;
  logic [1:0]       phase;
  logic [31:0]      crc;
  logic [LEN_W-1:0] len_cnt;
  logic             er_seen;
  logic [7:0]       hold_p1;
  logic             vld_p1;
  logic             sof_pend;

  logic pre_start, pre_inc, sfd_hit, dibit_shift, end_frame, drop_done;
  logic [7:0] byte_w;
  logic crc_ok_w, frame_err_w;

  // The fourth dibit lands in bits [7:6]; the earlier three are in asm_p1[7:2].
  assign byte_w      = {erxd_p0, asm_p1[7:2]};
  assign crc_ok_w    = (crc == CRC_RES);
  assign frame_err_w = er_seen | (phase != 2'd0) | (len_cnt < MIN_LEN_C) |
                       (len_cnt > MAX_LEN_C) | !crc_ok_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pre_start   = 1'b0;
    pre_inc     = 1'b0;
    sfd_hit     = 1'b0;
    dibit_shift = 1'b0;
    end_frame   = 1'b0;
    drop_done   = 1'b0;
    case (state_q)
      // END is a single cycle; it also watches the pins so a frame that
      // starts right after a one-cycle gap keeps its first preamble dibit.
      S_IDLE, S_END: begin
        end_frame = (state_q == S_END);
        if (!dv_p0) begin
          state_d = S_IDLE;
        end else if (erxd_p0 == 2'b01) begin
          state_d   = S_PRE;
          pre_start = 1'b1;
        end else begin
          state_d = S_DROP;
        end
      end
      S_PRE: begin
        if (!dv_p0) begin
          state_d = S_IDLE;
        end else if (erxd_p0 == 2'b01) begin
          pre_inc = 1'b1;
        end else if (erxd_p0 == 2'b11 && pre_cnt >= MIN_PRE_C) begin
          state_d = S_DATA;
          sfd_hit = 1'b1;
        end else begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!dv_p0) state_d = S_END;
        else        dibit_shift = 1'b1;
      end
      S_DROP: begin
        if (!dv_p0) begin
          state_d   = S_IDLE;
          drop_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage p2: output registers and statistics ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt     <= '0;
      asm_p1      <= 8'h00;
      phase       <= 2'd0;
      crc         <= 32'hFFFFFFFF;
      len_cnt     <= '0;
      er_seen     <= 1'b0;
      hold_p1     <= 8'h00;
      vld_p1      <= 1'b0;
      sof_pend    <= 1'b0;
      o_rx_data   <= 8'h00;
      o_rx_valid  <= 1'b0;
      o_rx_sof    <= 1'b0;
      o_rx_eof    <= 1'b0;
      o_rx_crc_ok <= 1'b0;
      o_rx_err    <= 1'b0;
      o_rx_len    <= '0;
      o_good_cnt  <= 16'h0000;
      o_bad_cnt   <= 16'h0000;
    end else begin
      o_rx_valid  <= 1'b0;
      o_rx_sof    <= 1'b0;
      o_rx_eof    <= 1'b0;
      o_rx_crc_ok <= 1'b0;
      o_rx_err    <= 1'b0;
      o_rx_len    <= '0;

      if (pre_start)    pre_cnt <= PRE_W'(1);
      else if (pre_inc) pre_cnt <= sat_inc_pre(pre_cnt);

      if (sfd_hit) begin
        crc      <= 32'hFFFFFFFF;
        len_cnt  <= '0;
        er_seen  <= 1'b0;
        phase    <= 2'd0;
        vld_p1   <= 1'b0;
        sof_pend <= 1'b1;
      end

      if (dibit_shift) begin
        if (er_p0) er_seen <= 1'b1;
        asm_p1 <= byte_w;
        phase  <= phase + 2'd1;
        if (phase == 2'd3) begin
          crc     <= crc_byte(crc, byte_w);
          len_cnt <= sat_inc_len(len_cnt);
          hold_p1 <= byte_w;
          vld_p1  <= 1'b1;
          // One-byte hold so the final byte can be tagged eof once dv drops.
          if (vld_p1) begin
            o_rx_data  <= hold_p1;
            o_rx_valid <= 1'b1;
            o_rx_sof   <= sof_pend;
            sof_pend   <= 1'b0;
          end
        end
      end

      if (end_frame) begin
        vld_p1   <= 1'b0;
        sof_pend <= 1'b0;
        if (vld_p1) begin
          o_rx_data   <= hold_p1;
          o_rx_valid  <= 1'b1;
          o_rx_sof    <= sof_pend;
          o_rx_eof    <= 1'b1;
          o_rx_crc_ok <= crc_ok_w;
          o_rx_err    <= frame_err_w;
          o_rx_len    <= len_cnt;
          if (frame_err_w) o_bad_cnt  <= sat_inc16(o_bad_cnt);
          else             o_good_cnt <= sat_inc16(o_good_cnt);
        end else begin
          o_bad_cnt <= sat_inc16(o_bad_cnt);
        end
      end

      if (drop_done) o_bad_cnt <= sat_inc16(o_bad_cnt);
    end
  end

endmodule
